// File: rtl/cdc_handshake_tx_if.sv
// Handshake bundle between the source-domain client, the transmitter and the far-domain receiver.
interface cdc_handshake_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             send;
  logic [WIDTH-1:0] data_in;
  logic             ready;
  logic             req_o;
  logic [WIDTH-1:0] data_o;
  logic             ack_i;
  logic             done;
  logic             drop;
  logic             timeout;

  // master: client plus far-end acknowledge; slave: the transmitter itself
  modport master (
    output send, data_in, ack_i,
    input  ready, req_o, data_o, done, drop, timeout
  );
  modport slave (
    input  send, data_in, ack_i,
    output ready, req_o, data_o, done, drop, timeout
  );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Source end of a 4-phase req/ack clock-domain crossing: holds a word on data_o, raises req_o and
// waits for the synchronized acknowledge to rise and fall again.
module cdc_handshake_tx #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 0
) (
  input logic                clk,
  input logic                reset,
  cdc_handshake_tx_if.slave  bus
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StRel} state_e;

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_q;
  logic [WIDTH-1:0]       data_q;
  logic                   done_q;
  logic                   timeout_q;
  logic [CntW-1:0]        cnt_q;

  logic ack_s;
  logic ack_nxt;
  logic ready;
  logic wd_expired;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ack_i};
    end
  end

  assign ack_s   = sync_q[SYNC_STAGES-1];
  // Value ack_s takes at the coming edge; lets done register in the first ack_s=1 cycle.
  assign ack_nxt = sync_q[SYNC_STAGES-2];

  assign ready      = (state_q == StIdle) && !ack_s;
  assign wd_expired = (TIMEOUT != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      req_q     <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.send && ready) begin
            data_q  <= bus.data_in;
            req_q   <= 1'b1;
            state_q <= StReq;
            cnt_q   <= '0;
          end
        end
        StReq: begin
          if (ack_nxt) begin
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StRel;
            cnt_q   <= '0;
          end else if (wd_expired) begin
            req_q     <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StRel: begin
          if (!ack_s) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (wd_expired) begin
            timeout_q <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ready   = ready;
  assign bus.req_o   = req_q;
  assign bus.data_o  = data_q;
  assign bus.done    = done_q;
  assign bus.drop    = bus.send && !ready;
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench: instance a (SYNC_STAGES=2, TIMEOUT=16) and instance b (SYNC_STAGES=3, no
// watchdog). Cycle n is observed 1 time unit after the n-th edge following an accept.
module tb_cdc_handshake_tx;

  logic clk;
  logic reset;
  logic loop_a, loop_b;
  logic ack_a, ack_b;
  int   total;
  int   bad;

  cdc_handshake_tx_if #(.WIDTH(8)) bus_a ();
  cdc_handshake_tx_if #(.WIDTH(8)) bus_b ();

  cdc_handshake_tx #(.WIDTH(8), .SYNC_STAGES(2), .TIMEOUT(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  cdc_handshake_tx #(.WIDTH(8), .SYNC_STAGES(3), .TIMEOUT(0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  always_comb bus_a.ack_i = loop_a ? bus_a.req_o : ack_a;
  always_comb bus_b.ack_i = loop_b ? bus_b.req_o : ack_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Loopback round trip on one instance after an accept in cycle 0.
  task automatic loop_run(input bit use_b, input logic [7:0] word, input int done_c,
                          input int ready_c, input string tag);
    if (use_b) begin bus_b.send = 1'b1; bus_b.data_in = word; end
    else       begin bus_a.send = 1'b1; bus_a.data_in = word; end
    #1;
    chk({tag, "_ready0"}, use_b ? bus_b.ready : bus_a.ready, 1);
    for (int c = 1; c <= ready_c; c++) begin
      nxt();
      bus_a.send = 1'b0;
      bus_b.send = 1'b0;
      #1;
      if (c == 1) begin
        chk({tag, "_req1"}, use_b ? bus_b.req_o : bus_a.req_o, 1);
        chk({tag, "_data1"}, use_b ? bus_b.data_o : bus_a.data_o, {24'd0, word});
      end
      chk($sformatf("%s_done_c%0d", tag, c), use_b ? bus_b.done : bus_a.done, (c == done_c));
      chk($sformatf("%s_ready_c%0d", tag, c), use_b ? bus_b.ready : bus_a.ready, (c == ready_c));
    end
  endtask

  initial begin
    int done_cnt, drop_cnt, done_at, idx;
    int done_cyc [3];
    total = 0;
    bad   = 0;
    reset = 1'b1;
    loop_a = 1'b0; loop_b = 1'b0;
    ack_a  = 1'b0; ack_b  = 1'b0;
    bus_a.send = 1'b0; bus_a.data_in = '0;
    bus_b.send = 1'b0; bus_b.data_in = '0;
    nxt();
    nxt();

    // Reset values
    chk("rst_req", bus_a.req_o, 0);
    chk("rst_data", bus_a.data_o, 0);
    chk("rst_done", bus_a.done, 0);
    chk("rst_drop", bus_a.drop, 0);
    chk("rst_timeout", bus_a.timeout, 0);
    chk("rst_ready", bus_a.ready, 1);
    reset = 1'b0;
    nxt();

    // 1: loopback, S=2: done at 3, ready at 6
    loop_a = 1'b1;
    loop_run(1'b0, 8'hA5, 3, 6, "t1");

    // 2: ack 10 cycles after req, extra sends at 2 and 5 are dropped
    loop_a = 1'b0;
    nxt();
    bus_a.send = 1'b1; bus_a.data_in = 8'h3C;
    done_cnt = 0; drop_cnt = 0; done_at = -1;
    for (int c = 1; c <= 24; c++) begin
      nxt();
      bus_a.send    = (c == 2) || (c == 5);
      bus_a.data_in = (c == 2) ? 8'hFF : 8'hEE;
      ack_a         = (c >= 11) && (c < 14);
      #1;
      if (bus_a.done) begin done_cnt++; done_at = c; end
      if (bus_a.drop) drop_cnt++;
      if (c == 2 || c == 5) chk($sformatf("t2_drop_c%0d", c), bus_a.drop, 1);
    end
    bus_a.send = 1'b0;
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_done_at", done_at, 13);
    chk("t2_drop_cnt", drop_cnt, 2);
    chk("t2_data_hold", bus_a.data_o, 8'h3C);
    chk("t2_ready_end", bus_a.ready, 1);

    // 3: back-to-back words on each first ready cycle, loopback
    loop_a = 1'b1;
    idx = 0; done_cnt = 0; drop_cnt = 0;
    for (int c = 0; c <= 40; c++) begin
      bus_a.send = 1'b0;
      if (bus_a.ready && idx < 3) begin
        bus_a.send    = 1'b1;
        bus_a.data_in = 8'(idx + 1);
        idx++;
      end
      #1;
      if (bus_a.drop) drop_cnt++;
      if (bus_a.done) begin
        if (done_cnt < 3) begin
          done_cyc[done_cnt] = c;
          chk($sformatf("t3_data_%0d", done_cnt), bus_a.data_o, done_cnt + 1);
        end
        done_cnt++;
      end
      nxt();
    end
    bus_a.send = 1'b0;
    chk("t3_done_cnt", done_cnt, 3);
    chk("t3_drop_cnt", drop_cnt, 0);
    chk("t3_done_cyc0", done_cyc[0], 3);
    chk("t3_done_cyc2", done_cyc[2], 15);

    // 4: watchdog with ack stuck low, then a late ack while idle
    loop_a = 1'b0;
    ack_a  = 1'b0;
    bus_a.send = 1'b1; bus_a.data_in = 8'h5A;
    done_cnt = 0;
    for (int c = 1; c <= 25; c++) begin
      nxt();
      bus_a.send = 1'b0;
      ack_a = (c >= 18) && (c <= 21);
      #1;
      if (bus_a.done) done_cnt++;
      if (c == 16) begin
        chk("t4_req_c16", bus_a.req_o, 1);
        chk("t4_to_c16", bus_a.timeout, 0);
      end
      if (c == 17) begin
        chk("t4_req_c17", bus_a.req_o, 0);
        chk("t4_to_c17", bus_a.timeout, 1);
        chk("t4_ready_c17", bus_a.ready, 1);
      end
      if (c == 20) chk("t4_late_ack_gate", bus_a.ready, 0);
      if (c == 24) chk("t4_late_ack_clear", bus_a.ready, 1);
    end
    chk("t4_sticky", bus_a.timeout, 1);
    chk("t4_no_done", done_cnt, 0);
    chk("t4_req_idle", bus_a.req_o, 0);

    // 5: reset while in REQ, ack held high for 4 cycles afterwards
    bus_a.send = 1'b1; bus_a.data_in = 8'h77;
    nxt();
    bus_a.send = 1'b0;
    #1;
    chk("t5_req_c1", bus_a.req_o, 1);
    nxt();
    reset = 1'b1;
    ack_a = 1'b1;
    nxt();
    reset = 1'b0;
    #1;
    chk("t5_req_c3", bus_a.req_o, 0);
    chk("t5_data_c3", bus_a.data_o, 0);
    chk("t5_to_c3", bus_a.timeout, 0);
    nxt();
    nxt();
    chk("t5_ready_c5", bus_a.ready, 0);
    nxt();
    ack_a = 1'b0;
    bus_a.send = 1'b1; bus_a.data_in = 8'h99;
    #1;
    chk("t5_ready_c6", bus_a.ready, 0);
    chk("t5_drop_c6", bus_a.drop, 1);
    nxt();
    bus_a.send = 1'b0;
    #1;
    chk("t5_ready_c7", bus_a.ready, 0);
    chk("t5_req_c7", bus_a.req_o, 0);
    nxt();
    chk("t5_ready_c8", bus_a.ready, 1);

    // 6: S=3 loopback: done at 4, ready at 8
    loop_b = 1'b1;
    loop_run(1'b1, 8'hC3, 4, 8, "t6");

    // No watchdog: ack stuck low never times out
    loop_b = 1'b0;
    ack_b  = 1'b0;
    nxt();
    bus_b.send = 1'b1; bus_b.data_in = 8'h11;
    for (int c = 1; c <= 40; c++) begin
      nxt();
      bus_b.send = 1'b0;
    end
    #1;
    chk("t6_no_timeout", bus_b.timeout, 0);
    chk("t6_req_held", bus_b.req_o, 1);
    chk("t6_data_held", bus_b.data_o, 8'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
